// File: rtl/tx_pkg.sv
// Shared FSM state type and byte constants for the transmit byte serialiser.
// StParity exists only when TX_BYTE_SERIALISER_PARITY_EN is defined.
package tx_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData
`ifdef TX_BYTE_SERIALISER_PARITY_EN
        ,
        StParity
`endif
    } tx_state_e;

    // A bit-count field of zero encodes a full byte.
    function automatic logic [3:0] bits_to_count(input logic [2:0] bits);
        return (bits == 3'd0) ? 4'(BITS_PER_BYTE) : {1'b0, bits};
    endfunction

endpackage

// File: rtl/tx_hold_buffer.sv
// One-entry byte buffer between the upstream frame source and the shift register.
// Generates the single-cycle in_req pulse and tracks the first byte of each frame.
module tx_hold_buffer
    import tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data_i,
    input  logic [2:0] in_data_bits_i,
    input  logic       in_data_valid_i,
    output logic       in_req_o,
    input  logic       take_i,
    input  logic       idle_i,
    output logic       hold_full_o,
    output logic [7:0] hold_data_o,
    output logic [3:0] hold_count_o
);

    logic       hold_full_q, hold_full_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic [2:0] hold_bits_q, hold_bits_d;
    logic       hold_first_q, hold_first_d;
    logic       first_q, first_d;
    logic       guard_q, guard_d;
    logic       fill;

    // The in_req cycle doubles as the guard cycle while upstream swaps its byte.
    assign fill = !hold_full_q && in_data_valid_i && !guard_q;

    always_comb begin
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_bits_d  = hold_bits_q;
        hold_first_d = hold_first_q;
        first_d      = first_q;
        guard_d      = fill;
        if (take_i) begin
            hold_full_d = 1'b0;
        end
        if (fill) begin
            hold_full_d  = 1'b1;
            hold_data_d  = in_data_i;
            hold_bits_d  = in_data_bits_i;
            hold_first_d = first_q;
            first_d      = 1'b0;
        end else if (idle_i && !hold_full_q && !in_data_valid_i && !guard_q) begin
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q  <= 1'b0;
            hold_data_q  <= 8'h00;
            hold_bits_q  <= 3'd0;
            hold_first_q <= 1'b0;
            first_q      <= 1'b1;
            guard_q      <= 1'b0;
        end else begin
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_bits_q  <= hold_bits_d;
            hold_first_q <= hold_first_d;
            first_q      <= first_d;
            guard_q      <= guard_d;
        end
    end

    assign in_req_o     = guard_q;
    assign hold_full_o  = hold_full_q;
    assign hold_data_o  = hold_data_q;
    assign hold_count_o = hold_first_q ? bits_to_count(hold_bits_q) : 4'(BITS_PER_BYTE);

endmodule

// File: rtl/tx_byte_serialiser.sv
// Serialises upstream bytes LSB first to a bit encoder under an out_req handshake.
// Define TX_BYTE_SERIALISER_PARITY_EN to append a parity bit to every full byte.
module tx_byte_serialiser
    import tx_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic [2:0] in_data_bits,
    input  logic       in_data_valid,
    output logic       in_req,
    output logic       out_data,
    output logic       out_data_valid,
    output logic       out_last_bit_in_byte,
    input  logic       out_req
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] count_q, count_d;
    logic       take;
    logic       byte_done;
    logic       hold_full;
    logic [7:0] hold_data;
    logic [3:0] hold_count;

`ifdef TX_BYTE_SERIALISER_PARITY_EN
    logic       parity_q, parity_d;
    logic       full_q, full_d;
`else
    logic       unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    tx_hold_buffer u_hold_buffer (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data_i       (in_data),
        .in_data_bits_i  (in_data_bits),
        .in_data_valid_i (in_data_valid),
        .in_req_o        (in_req),
        .take_i          (take),
        .idle_i          (state_q == StIdle),
        .hold_full_o     (hold_full),
        .hold_data_o     (hold_data),
        .hold_count_o    (hold_count)
    );

    always_comb begin
        state_d              = state_q;
        shift_d              = shift_q;
        count_d              = count_q;
        take                 = 1'b0;
        byte_done            = 1'b0;
        out_data             = 1'b0;
        out_data_valid       = 1'b0;
        out_last_bit_in_byte = 1'b0;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
        parity_d             = parity_q;
        full_d               = full_q;
`endif
        case (state_q)
            StIdle: begin
                byte_done = 1'b1;
            end
            StData: begin
                out_data       = shift_q[0];
                out_data_valid = 1'b1;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
                out_last_bit_in_byte = (count_q == 4'd1) && !full_q;
`else
                out_last_bit_in_byte = (count_q == 4'd1);
`endif
                if (out_req) begin
                    shift_d = shift_q >> 1;
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd1) begin
`ifdef TX_BYTE_SERIALISER_PARITY_EN
                        if (full_q) begin
                            state_d = StParity;
                        end else begin
                            byte_done = 1'b1;
                        end
`else
                        byte_done = 1'b1;
`endif
                    end
                end
            end
`ifdef TX_BYTE_SERIALISER_PARITY_EN
            StParity: begin
                out_data             = parity_q;
                out_data_valid       = 1'b1;
                out_last_bit_in_byte = 1'b1;
                byte_done            = out_req;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // A finished byte chains straight into a buffered one so no valid gap appears.
        if (byte_done) begin
            if (hold_full) begin
                state_d = StData;
                shift_d = hold_data;
                count_d = hold_count;
                take    = 1'b1;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
                parity_d = (^hold_data) ^ PARITY_ODD;
                full_d   = (hold_count == 4'(BITS_PER_BYTE));
`endif
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= 8'h00;
            count_q  <= 4'd0;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
            parity_q <= 1'b0;
            full_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
            parity_q <= parity_d;
            full_q   <= full_d;
`endif
        end
    end

endmodule

// File: tb/tb_tx_byte_serialiser.sv
// Directed, table-driven bench for tx_byte_serialiser; expectations follow
// TX_BYTE_SERIALISER_PARITY_EN when it is defined.
module tb_tx_byte_serialiser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data;
    logic [2:0] in_data_bits;
    logic       in_data_valid;
    logic       in_req;
    logic       out_data;
    logic       out_data_valid;
    logic       out_last_bit_in_byte;
    logic       out_req;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b0;
        logic [2:0] bits0;
        logic [7:0] b1;
        logic [2:0] bits1;
        int         nbytes;
        bit         slow;
        string      exp_bits;
        string      exp_last;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    tx_byte_serialiser dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_data              (in_data),
        .in_data_bits         (in_data_bits),
        .in_data_valid        (in_data_valid),
        .in_req               (in_req),
        .out_data             (out_data),
        .out_data_valid       (out_data_valid),
        .out_last_bit_in_byte (out_last_bit_in_byte),
        .out_req              (out_req)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] b0, input logic [2:0] bits0,
                           input logic [7:0] b1, input logic [2:0] bits1, input int nbytes,
                           input bit slow, input string eb, input string el);
        vecs[i].b0       = b0;
        vecs[i].bits0    = bits0;
        vecs[i].b1       = b1;
        vecs[i].bits1    = bits1;
        vecs[i].nbytes   = nbytes;
        vecs[i].slow     = slow;
        vecs[i].exp_bits = eb;
        vecs[i].exp_last = el;
    endtask

    // Presents one frame, plays downstream, compares every consumed bit.
    task automatic run_frame(input int v);
        int k = 0;
        int idx = 0;
        int gaps = 0;
        int reqs = 0;
        int wide = 0;
        bit prev_req = 1'b0;
        bit take;
        int n;
        int eb;
        int el;
        n = vecs[v].exp_bits.len();
        in_data       = vecs[v].b0;
        in_data_bits  = vecs[v].bits0;
        in_data_valid = 1'b1;
        out_req       = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk);
            #1;
            if (in_req) begin
                reqs++;
                if (prev_req) wide++;
                idx++;
                if (idx < vecs[v].nbytes) begin
                    in_data      = vecs[v].b1;
                    in_data_bits = vecs[v].bits1;
                end else begin
                    in_data_valid = 1'b0;
                end
            end
            prev_req = in_req;
            take = out_data_valid && (!vecs[v].slow || (cyc % 2 == 1));
            if (take) begin
                if (k < n) begin
                    eb = (vecs[v].exp_bits.getc(k) == 8'h31) ? 1 : 0;
                    el = (vecs[v].exp_last.getc(k) == 8'h31) ? 1 : 0;
                    check($sformatf("v%0d bit%0d data", v, k), int'(out_data), eb);
                    check($sformatf("v%0d bit%0d last", v, k), int'(out_last_bit_in_byte), el);
                end
                k++;
            end else if (!vecs[v].slow && !out_data_valid && k > 0 && k < n) begin
                gaps++;
            end
            out_req = take;
        end
        out_req = 1'b0;
        check($sformatf("v%0d bit count", v), k, n);
        if (!vecs[v].slow) check($sformatf("v%0d valid gaps", v), gaps, 0);
        check($sformatf("v%0d in_req pulses", v), reqs, vecs[v].nbytes);
        check($sformatf("v%0d in_req wide", v), wide, 0);
        check($sformatf("v%0d valid after frame", v), int'(out_data_valid), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " in_req"}, int'(in_req), 0);
        check({tag, " out_data"}, int'(out_data), 0);
        check({tag, " out_data_valid"}, int'(out_data_valid), 0);
        check({tag, " out_last"}, int'(out_last_bit_in_byte), 0);
    endtask

    initial begin
        int k;
`ifdef TX_BYTE_SERIALISER_PARITY_EN
        set_vec(0, 8'hA5, 3'd0, 8'h00, 3'd0, 1, 1'b0, "101001011", "000000001");
        set_vec(1, 8'h26, 3'd7, 8'h00, 3'd0, 1, 1'b0, "0110010", "0000001");
        set_vec(2, 8'h93, 3'd0, 8'h20, 3'd5, 2, 1'b0,
                "110010011000001000", "000000001000000001");
        set_vec(3, 8'hFF, 3'd0, 8'h00, 3'd0, 1, 1'b1, "111111111", "000000001");
        set_vec(4, 8'h3C, 3'd4, 8'hC3, 3'd5, 2, 1'b0, "0011110000111", "0001000000001");
        set_vec(5, 8'h0F, 3'd0, 8'h00, 3'd0, 1, 1'b0, "111100001", "000000001");
`else
        set_vec(0, 8'hA5, 3'd0, 8'h00, 3'd0, 1, 1'b0, "10100101", "00000001");
        set_vec(1, 8'h26, 3'd7, 8'h00, 3'd0, 1, 1'b0, "0110010", "0000001");
        set_vec(2, 8'h93, 3'd0, 8'h20, 3'd5, 2, 1'b0,
                "1100100100000100", "0000000100000001");
        set_vec(3, 8'hFF, 3'd0, 8'h00, 3'd0, 1, 1'b1, "11111111", "00000001");
        set_vec(4, 8'h3C, 3'd4, 8'hC3, 3'd5, 2, 1'b0, "001111000011", "000100000001");
        set_vec(5, 8'h0F, 3'd0, 8'h00, 3'd0, 1, 1'b0, "11110000", "00000001");
`endif
        rst_n         = 1'b0;
        in_data       = 8'h5A;
        in_data_bits  = 3'd0;
        in_data_valid = 1'b1;
        out_req       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");

        in_data_valid = 1'b0;
        rst_n         = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_quiet("idle");
        end
        out_req = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_frame(v);
            out_req = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1;
                check($sformatf("gap%0d idle valid", v), int'(out_data_valid), 0);
            end
            out_req = 1'b0;
        end

        // Abandon a frame three bits in, then send a fresh one.
        in_data       = 8'h55;
        in_data_bits  = 3'd0;
        in_data_valid = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
            @(posedge clk);
            #1;
            if (in_req) in_data_valid = 1'b0;
            if (out_data_valid) begin
                check($sformatf("pre-reset bit%0d", k), int'(out_data), (k % 2 == 0) ? 1 : 0);
                k++;
                out_req = 1'b1;
            end else begin
                out_req = 1'b0;
            end
        end
        check("pre-reset bit count", k, 3);
        @(posedge clk);
        #1;
        out_req       = 1'b0;
        in_data       = 8'h0F;
        in_data_bits  = 3'd0;
        in_data_valid = 1'b1;
        rst_n         = 1'b0;
        #1;
        check_quiet("mid reset");
        repeat (2) @(posedge clk);
        #1;
        check_quiet("held reset");
        rst_n = 1'b1;
        run_frame(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_byte_serialiser.md
TX_BYTE_SERIALISER -- requirements
Module: tx_byte_serialiser

Interface
REQ-001 SHALL have a compile-time setting PARITY_ODD, default 1, meaning a generated parity bit (REQ-021) makes each data byte plus its parity bit contain an odd number of ones.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 in_data  input  8  byte from the upstream frame source, sent LSB first.
REQ-005 in_data_bits  input  3  valid bits in the first byte of a frame; 0 means 8.
REQ-006 in_data_valid  input  1  upstream has a byte presented; low means end of frame.
REQ-007 in_req  output  1  one-cycle pulse: presented byte has been taken; present the next.
REQ-008 out_data  output  1  current bit to the downstream bit encoder.
REQ-009 out_data_valid  output  1  out_data is meaningful.
REQ-010 out_last_bit_in_byte  output  1  out_data is the final bit of the current byte, including its parity bit if one is sent.
REQ-011 out_req  input  1  one-cycle pulse from downstream: current bit consumed; present the next.

Function
REQ-012 SHALL hold one byte in a hold buffer (data, bit count, first-byte flag) and one byte in a shift register.
REQ-013 SHALL set hold_full and pulse in_req for exactly one cycle when the buffer is empty, in_data_valid=1 and no guard cycle is active.
REQ-014 SHALL ignore in_data, in_data_bits and in_data_valid in the cycle after an in_req pulse (guard cycle), while upstream updates.
REQ-015 SHALL honour in_data_bits only for the first byte of a frame; every later byte carries 8 bits.
REQ-016 FSM states: IDLE, DATA, PARITY.
REQ-017 IDLE -> DATA when hold_full: move the buffer to the shift register and load count = bits (0 becomes 8).
REQ-018 In DATA, SHALL drive out_data=shift[0] and out_data_valid=1.
REQ-019 On out_req in DATA, SHALL shift right and decrement count.
REQ-020 When count reaches 0: go to PARITY if enabled (REQ-030) and count was 8; else to DATA if hold_full (reload the shift register); else to IDLE with out_data_valid=0.
REQ-021 In PARITY, SHALL present the parity bit computed over the 8 data bits.
REQ-022 On out_req in PARITY, SHALL follow the same next-state rule as REQ-020.
REQ-023 SHALL assert out_last_bit_in_byte when presenting the final bit of the byte (count=1 with no parity to follow, or in PARITY), else 0.
REQ-024 When a byte is already buffered, the next bit SHALL be valid on out_data the cycle after out_req, with no out_data_valid gap across byte boundaries.
REQ-025 End of frame is in_data_valid=0 while the buffer is empty at a byte boundary; the first-byte flag SHALL be rearmed for the next frame.
REQ-026 out_req while out_data_valid=0 SHALL be ignored.
REQ-027 Simultaneous buffer fill and shift-register load SHALL take the old buffer contents first, with no byte lost or duplicated.

Reset
REQ-028 While rst_n=0: in_req=0, out_data=0, out_data_valid=0, out_last_bit_in_byte=0, FSM=IDLE, hold_full=0, guard cycle inactive, first-byte flag set.
REQ-029 Reset mid-frame SHALL abandon the frame; after release the block SHALL idle until in_data_valid=1.

Configuration
REQ-030 Macro TX_BYTE_SERIALISER_PARITY_EN defined: a parity bit SHALL follow every full 8-bit byte; partial first bytes get none.
REQ-031 Macro undefined: PARITY state and parity logic SHALL be absent, with the final data bit flagged last.

Structure
REQ-032 Package tx_pkg SHALL hold the FSM state enum and the BITS_PER_BYTE=8 constant.
REQ-033 Sub-module tx_hold_buffer SHALL implement the one-entry buffer, in_req pulse and guard cycle (REQ-013, REQ-014).

Verification
REQ-034 Frame {0xA5}, bits=0, parity on -> out 1,0,1,0,0,1,0,1 then parity 1; last=1 only on the parity bit.
REQ-035 Frame {0x26}, bits=7, parity on -> 7 bits 0,1,1,0,0,1,0; no parity; last on bit 7; then out_data_valid=0.
REQ-036 Frame {0x93,0x20} with back-to-back out_req -> 18 bits with no out_data_valid gap; in_req pulses exactly twice, each one cycle.
REQ-037 Parity macro undefined, frame {0xFF} -> 8 ones; last on bit 8; no ninth bit.
REQ-038 rst_n low after 3 bits of {0x55}, then {0x0F} -> outputs zero during reset; 0x0F then serialised from its bit 0.
